run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 8: program-counter width in bits.
REQ-002 Parameter MAX_CYC, default 255: watchdog limit, counted in run cycles.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  start request, sampled only in IDLE.
REQ-006 start_addr  in  PC_W  first instruction address, captured when req is accepted.
REQ-007 instr  in  9  instruction word at address pc, returned combinationally by instruction memory.
REQ-008 br_taken  in  1  core branch decision, valid in EXEC.
REQ-009 br_target  in  PC_W  branch destination, valid in EXEC.
REQ-010 mem_rdy  in  1  data-memory completion for the current access.
REQ-011 pc  out  PC_W  current fetch address.
REQ-012 ir  out  9  latched instruction driven to the core decoder.
REQ-013 exec_en  out  1  one-cycle pulse that lets the core commit the register-file write for ir.
REQ-014 mem_req  out  1  data-memory access strobe; mem_we is 1 for a store.
REQ-015 mem_we  out  1  store qualifier, valid only while mem_req is 1.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 ack  out  1  one-cycle completion pulse.
REQ-018 timeout  out  1  last run ended by the watchdog.
REQ-019 instr_cnt  out  16  number of instructions retired in the current or last run.

Function
REQ-020 The FSM shall have exactly five states: IDLE, FETCH, EXEC, MEM and DONE.
REQ-021 IDLE with req=1: pc<=start_addr, instr_cnt<=0, cycle counter<=0, timeout<=0, next state FETCH; with req=0 stay in IDLE.
REQ-022 req shall be ignored in every state other than IDLE, and no start shall be queued.
REQ-023 FETCH: ir<=instr, next state EXEC; fetch latency is exactly 1 cycle.
REQ-024 EXEC with opcode ir[8:5]==OP_HALT: next state DONE; no exec_en, no pc change, no count increment.
REQ-025 EXEC with opcode OP_LW or OP_SW: next state MEM; no exec_en pulse in EXEC.
REQ-026 EXEC with any other opcode: exec_en=1 for that cycle, retire, next state FETCH.
REQ-027 Retire: pc<=br_target if br_taken, else pc+1 (wraps modulo 2^PC_W); instr_cnt increments and saturates at 0xFFFF.
REQ-028 MEM: mem_req=1 every cycle until mem_rdy=1, with mem_we=1 for OP_SW and 0 for OP_LW.
REQ-029 MEM with mem_rdy=1: exec_en=1 if the opcode is OP_LW, retire with br_taken treated as 0, next state FETCH.
REQ-030 mem_rdy while not in MEM shall be ignored.
REQ-031 The cycle counter shall increment every cycle in FETCH, EXEC or MEM.
REQ-032 When the cycle counter reaches MAX_CYC and the current cycle is not a halt: timeout<=1, next state DONE, no exec_en or retire in that cycle.
REQ-033 Halt and watchdog expiry in the same cycle: halt wins and timeout stays 0.
REQ-034 DONE: ack=1 for exactly one cycle, next state IDLE.
REQ-035 timeout and instr_cnt shall hold their values until the next accepted req.
REQ-036 Minimum run for a lone HALT: req accepted at cycle 0, ack at cycle 3.

Reset
REQ-037 reset=0 shall asynchronously force state=IDLE and every output and register to 0, including in mid-run or mid-MEM, and shall drop mem_req immediately.
REQ-038 After reset is released, the first req shall behave identically to a req after power-up.

Structure
REQ-039 Package roe_pkg shall hold the state enum, the opcode field position, and the constants OP_LW=4'b1000, OP_SW=4'b1001 and OP_HALT=4'b1111.
REQ-040 The watchdog shall be one sub-module, run_wdog (counter, clear, expire flag); all other logic stays in run_ctrl.

Verification
REQ-041 start_addr=0x10, instr at 0x10 = HALT, req pulse -> ack 3 cycles after acceptance, instr_cnt=0, pc=0x10, timeout=0.
REQ-042 Three ALU ops then HALT from 0x00 -> three exec_en pulses, instr_cnt=3, pc=0x03 at ack.
REQ-043 LW at 0x05, mem_rdy delayed 4 cycles -> mem_req high 5 cycles, mem_we=0, one exec_en on the mem_rdy cycle, pc=0x06.
REQ-044 Branch at 0xFF with br_taken=0 and PC_W=8 -> pc wraps to 0x00; with br_taken=1 and br_target=0x40 -> pc=0x40.
REQ-045 Tight loop (br_taken=1, br_target=pc), MAX_CYC=20 -> ack with timeout=1 after 20 run cycles; req pulses during the run are ignored.
REQ-046 reset=0 asserted in MEM with mem_req=1 -> mem_req, busy and ack at 0 immediately; a new req runs normally.

Source files
------------

// File: rtl/roe_pkg.sv
// Shared types and opcode constants for the run controller and its watchdog.
// The opcode is the top four bits of the 9-bit instruction word.
package roe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 5;

  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/run_wdog.sv
// Run-cycle watchdog: counts cycles while the controller is running and flags
// the cycle that brings the count to MAX_CYC.
module run_wdog #(
  parameter int MAX_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // expire marks the MAX_CYC-th run cycle itself, so the run stops right there
  assign expire = run && (cnt == CNT_W'(MAX_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Sequencer that fetches, executes and retires instructions from start_addr
// until a HALT or a watchdog expiry, then pulses ack.
module run_ctrl
  import roe_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int MAX_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [PC_W-1:0] start_addr,
  input  logic [8:0]      instr,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            mem_rdy,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      ir,
  output logic            exec_en,
  output logic            mem_req,
  output logic            mem_we,
  output logic            busy,
  output logic            ack,
  output logic            timeout,
  output logic [15:0]     instr_cnt
);

  state_t     state, state_nx;
  logic [3:0] op;
  logic       accept;
  logic       retire;
  logic       take_br;
  logic       wd_stop;
  logic       running;
  logic       expire;

  assign op      = ir[OP_MSB:OP_LSB];
  assign running = (state == FETCH) || (state == EXEC) || (state == MEM);
  assign busy    = (state != IDLE);
  assign ack     = (state == DONE);

  run_wdog #(
    .MAX_CYC (MAX_CYC)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .run    (running),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // HALT is checked ahead of the watchdog so a halt on the final cycle ends cleanly
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    retire   = 1'b0;
    take_br  = 1'b0;
    wd_stop  = 1'b0;
    exec_en  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (expire) begin
          wd_stop  = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (op == OP_HALT) begin
          state_nx = DONE;
        end else if (expire) begin
          wd_stop  = 1'b1;
          state_nx = DONE;
        end else if (is_mem_op(op)) begin
          state_nx = MEM;
        end else begin
          exec_en  = 1'b1;
          retire   = 1'b1;
          take_br  = br_taken;
          state_nx = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (expire) begin
          wd_stop  = 1'b1;
          state_nx = DONE;
        end else if (mem_rdy) begin
          exec_en  = (op == OP_LW);
          retire   = 1'b1;
          state_nx = FETCH;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ir        <= '0;
      instr_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (accept) begin
        pc        <= start_addr;
        instr_cnt <= '0;
        timeout   <= 1'b0;
      end
      if (state == FETCH) begin
        ir <= instr;
      end
      if (retire) begin
        pc <= take_br ? br_target : pc + PC_W'(1);
        if (instr_cnt != 16'hFFFF) begin
          instr_cnt <= instr_cnt + 16'd1;
        end
      end
      if (wd_stop) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus random programs, each checked
// against an instruction-level cycle-cost model of a run.
module tb_run_ctrl;

  localparam int PC_W = 8;
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic [8:0]  instr;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        mem_rdy = 1'b0;
  logic [7:0]  pc;
  logic [8:0]  ir;
  logic        exec_en, mem_req, mem_we, busy, ack, timeout;
  logic [15:0] instr_cnt;

  logic [8:0] imem    [256];
  logic       bt_tab  [256];
  logic [7:0] tgt_tab [256];
  int         lat_tab [256];

  int total = 0;
  int bad   = 0;

  int         e_cyc, e_cnt, e_ex, e_mrq, last_c;
  logic [7:0] e_pc;
  logic       e_to;

  assign instr = imem[pc];

  always #5 clk = ~clk;

  run_ctrl #(
    .PC_W    (PC_W),
    .MAX_CYC (MAXC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .start_addr (start_addr),
    .instr      (instr),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_rdy    (mem_rdy),
    .pc         (pc),
    .ir         (ir),
    .exec_en    (exec_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .busy       (busy),
    .ack        (ack),
    .timeout    (timeout),
    .instr_cnt  (instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op);
    return {op, 5'(($urandom))};
  endfunction

  // Cost model: FETCH and EXEC take one run cycle each, a memory op adds
  // latency+1 cycles; the run stops on HALT or on the MAXC-th run cycle.
  task automatic model_run(input logic [7:0] s);
    int         t;
    logic [7:0] p;
    logic [3:0] op;
    bit         stop;
    t = 0; p = s; stop = 0;
    e_cnt = 0; e_to = 0; e_ex = 0; e_mrq = 0;
    while (!stop) begin
      t++;
      if (t == MAXC) begin e_to = 1; break; end
      op = imem[p][8:5];
      t++;
      if (op == 4'hF) break;
      if (t == MAXC) begin e_to = 1; break; end
      if (op == 4'h8 || op == 4'h9) begin
        for (int k = 0; k <= lat_tab[p]; k++) begin
          t++;
          e_mrq++;
          if (t == MAXC) begin e_to = 1; stop = 1; break; end
        end
        if (stop) break;
        if (op == 4'h8) e_ex++;
        p = p + 8'd1;
      end else begin
        e_ex++;
        p = bt_tab[p] ? tgt_tab[p] : p + 8'd1;
      end
      e_cnt++;
    end
    e_pc  = p;
    e_cyc = t + 1;
  endtask

  task automatic run_prog(input string tag, input logic [7:0] s, input bit noise);
    int c, exn, mrq, mc;
    bit we_ok, done;
    model_run(s);
    @(negedge clk);
    start_addr = s; req = 1'b1; mem_rdy = 1'b0;
    @(negedge clk);
    req = 1'b0;
    c = 1; exn = 0; mrq = 0; mc = 0; we_ok = 1; done = 0;
    while (!done && c < 200) begin
      if (ack) begin
        done = 1;
      end else begin
        br_taken  = bt_tab[pc];
        br_target = tgt_tab[pc];
        if (mem_req) begin
          mem_rdy = (mc == lat_tab[pc]);
          mc = mem_rdy ? 0 : mc + 1;
        end else begin
          mem_rdy = 1'($urandom_range(0, 1));
        end
        req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (exec_en) exn++;
        if (mem_req) begin
          mrq++;
          if (mem_we !== (imem[pc][8:5] == 4'h9)) we_ok = 0;
        end
        @(negedge clk);
        c++;
      end
    end
    req = 1'b0;
    last_c = c;
    chk({tag, ":ack_seen"}, 32'(done), 32'd1);
    chk({tag, ":ack_cyc"}, 32'(c), 32'(e_cyc));
    chk({tag, ":cnt"}, 32'(instr_cnt), 32'(e_cnt));
    chk({tag, ":pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ":timeout"}, 32'(timeout), 32'(e_to));
    chk({tag, ":exec_en"}, 32'(exn), 32'(e_ex));
    chk({tag, ":mem_req"}, 32'(mrq), 32'(e_mrq));
    chk({tag, ":mem_we"}, 32'(we_ok), 32'd1);
    repeat (3) begin
      @(negedge clk);
      mem_rdy = 1'($urandom_range(0, 1));
    end
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ":hold_cnt"}, 32'(instr_cnt), 32'(e_cnt));
    chk({tag, ":hold_to"}, 32'(timeout), 32'(e_to));
    mem_rdy = 1'b0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) begin
      imem[i] = {4'hF, 5'd0}; bt_tab[i] = 1'b0; tgt_tab[i] = 8'h00; lat_tab[i] = 0;
    end

    // Reset state
    #3;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_exec_en", 32'(exec_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Lone HALT
    imem[8'h10] = mk(4'hF);
    run_prog("halt", 8'h10, 1'b0);
    chk("halt_latency", 32'(last_c), 32'd3);

    // Three ALU ops then HALT
    imem[0] = mk(4'h1); imem[1] = mk(4'h2); imem[2] = mk(4'h3); imem[3] = mk(4'hF);
    run_prog("alu3", 8'h00, 1'b0);

    // LW with delayed mem_rdy
    imem[5] = mk(4'h8); lat_tab[5] = 4; imem[6] = mk(4'hF);
    run_prog("lw", 8'h05, 1'b0);

    // SW
    imem[8'h20] = mk(4'h9); lat_tab[8'h20] = 2; imem[8'h21] = mk(4'hF);
    run_prog("sw", 8'h20, 1'b0);

    // PC wrap and taken branch
    imem[8'hFF] = mk(4'h4); imem[0] = mk(4'hF);
    run_prog("wrap", 8'hFF, 1'b0);
    bt_tab[8'hFF] = 1'b1; tgt_tab[8'hFF] = 8'h40; imem[8'h40] = mk(4'hF);
    run_prog("branch", 8'hFF, 1'b0);

    // Tight loop hits the watchdog, req noise meanwhile
    imem[8'h80] = mk(4'h2); bt_tab[8'h80] = 1'b1; tgt_tab[8'h80] = 8'h80;
    run_prog("loop", 8'h80, 1'b1);
    chk("loop_latency", 32'(last_c), 32'(MAXC + 1));

    // Async reset in MEM
    lat_tab[5] = 100;
    @(negedge clk);
    start_addr = 8'h05; req = 1'b1;
    @(negedge clk);
    req = 1'b0; mem_rdy = 1'b0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req) seen = 1;
      else @(negedge clk);
    end
    chk("rst_mid_saw_mem", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_pc", 32'(pc), 32'd0);
    chk("rst_mid_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    lat_tab[5] = 1;
    run_prog("post_rst", 8'h05, 1'b0);

    // Random programs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 2)       imem[i] = mk(4'hF);
        else if (sel == 2) imem[i] = mk(4'h8);
        else if (sel == 3) imem[i] = mk(4'h9);
        else               imem[i] = mk(4'($urandom_range(0, 7)));
        bt_tab[i]  = ($urandom_range(0, 3) == 0);
        tgt_tab[i] = 8'($urandom);
        lat_tab[i] = $urandom_range(0, 3);
      end
      run_prog($sformatf("rnd%0d", r), 8'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
